seg_scroll_ctrl: RTL and testbench

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

---
 rtl/seg_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 81 ++++++++
 rtl/seg_scroll_ctrl.sv | 109 ++++++++++
 tb/tb_seg_scroll_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and button-FSM encoding for the segment scroller.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    localparam int MSG_DEPTH = 16;
    localparam int CHAR_W    = 4;
    localparam int IDX_W     = $clog2(MSG_DEPTH);
    localparam int WIN_CHARS = 4;
    localparam int WIN_W     = WIN_CHARS * CHAR_W;

    // Window contents implied by the reset message at base 0
    localparam logic [WIN_W-1:0] WIN_RESET = 16'h0123;

    typedef enum logic [1:0] {
        BTN_RELEASED,
        BTN_PRESS_DB,
        BTN_PRESSED,
        BTN_RELEASE_DB
    } btn_state_t;

    function automatic logic [CHAR_W-1:0] init_char(input int slot);
        return CHAR_W'(slot % 10);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes an active-low button and debounces it into a one-cycle press pulse.
// Latency: 2 sync cycles plus DB_CYCLES of stable low level before press fires.
// Backpressure: none; holding the button produces a single pulse.
module btn_debounce
    import seg_pkg::*;
#(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_low;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n};
    end

    assign btn_low = ~sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= BTN_RELEASED;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // The sample that enters a DB state is the first of the stable run, so the count starts at 1
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = '0;
        press      = 1'b0;
        case (state)
            BTN_RELEASED: begin
                if (btn_low) begin
                    state_nxt  = BTN_PRESS_DB;
                    db_cnt_nxt = CNT_W'(1);
                end
            end
            BTN_PRESS_DB: begin
                if (!btn_low) begin
                    state_nxt = BTN_RELEASED;
                end else if (db_cnt >= DB_LAST) begin
                    state_nxt = BTN_PRESSED;
                    press     = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            BTN_PRESSED: begin
                if (!btn_low) begin
                    state_nxt  = BTN_RELEASE_DB;
                    db_cnt_nxt = CNT_W'(1);
                end
            end
            BTN_RELEASE_DB: begin
                if (btn_low) begin
                    state_nxt = BTN_PRESSED;
                end else if (db_cnt >= DB_LAST) begin
                    state_nxt = BTN_RELEASED;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = BTN_RELEASED;
        endcase
    end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolls a 16-character message across a 4-digit window by button page or timed auto step.
// Latency: step_pulse/base_idx one cycle after an event; window one cycle after base or write.
// Backpressure: none; one write accepted every cycle, events never stall.
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int DB_CYCLES    = 20000,
    parameter int TICK_DIV     = 50000,
    parameter int SCROLL_TICKS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_n,
    input  logic              auto_en,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    output logic              digit_tick,
    output logic [WIN_W-1:0]  window,
    output logic [IDX_W-1:0]  base_idx,
    output logic              step_pulse
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int SC_W   = $clog2(SCROLL_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(SCROLL_TICKS - 1);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic              page_evt;
    logic              auto_evt;
    logic [TICK_W-1:0] tick_cnt;
    logic [SC_W-1:0]   auto_cnt;
    logic [CHAR_W-1:0] msg [MSG_DEPTH];
    logic [WIN_W-1:0]  window_nxt;

    // Assert immediately, release two edges later so nothing moves on the release edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (rst_n),
        .btn_n (btn_n),
        .press (page_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            digit_tick <= 1'b0;
        end else begin
            tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            digit_tick <= (tick_cnt == TICK_LAST);
        end
    end

    assign auto_evt = auto_en && digit_tick && (auto_cnt == SC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!auto_en || page_evt) begin
            auto_cnt <= '0;
        end else if (digit_tick) begin
            auto_cnt <= auto_evt ? '0 : auto_cnt + 1'b1;
        end
    end

    // Page wins a collision with auto; the auto count is cleared by the page event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_idx   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= page_evt || auto_evt;
            if (page_evt)      base_idx <= base_idx + IDX_W'(WIN_CHARS);
            else if (auto_evt) base_idx <= base_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg[i] <= init_char(i);
        end else if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        window_nxt = '0;
        for (int i = 0; i < WIN_CHARS; i++) begin
            window_nxt[CHAR_W*(WIN_CHARS-1-i) +: CHAR_W] = msg[base_idx + IDX_W'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) window <= WIN_RESET;
        else        window <= window_nxt;
    end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl with short debounce/tick/scroll parameters.
// Expected base_idx values are queued as stimulus is driven and popped on each step_pulse.
module tb_seg_scroll_ctrl;

    localparam int DB = 4;
    localparam int TD = 8;
    localparam int ST = 3;
    localparam int AUTO_PERIOD = TD * ST;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_n = 1'b1;
    logic        auto_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_data = 4'd0;
    logic        digit_tick;
    logic [15:0] window;
    logic [3:0]  base_idx;
    logic        step_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q[$];

    seg_scroll_ctrl #(
        .DB_CYCLES   (DB),
        .TICK_DIV    (TD),
        .SCROLL_TICKS(ST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .auto_en    (auto_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_tick (digit_tick),
        .window     (window),
        .base_idx   (base_idx),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clk1();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, output int steps);
        steps = 0;
        repeat (n) begin
            clk1();
            if (step_pulse) steps++;
        end
    endtask

    // Waits for the next step_pulse and scores base_idx against the queue head
    task automatic wait_step(input string name, input int budget, output int t);
        bit seen;
        int e;
        seen = 1'b0;
        t = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            clk1();
            if (step_pulse) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: no step_pulse within %0d cycles, required one", name, budget);
        end else begin
            t = cyc;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s_unexpected: step with base_idx=%0d, required no step", name, base_idx);
            end else begin
                e = exp_q.pop_front();
                if (base_idx !== 4'(e)) begin
                    n_err++;
                    $display("FAIL %s_base: base_idx=%0d, required %0d", name, base_idx, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn_n = 1'b1;
        auto_en = 1'b0;
        wr_en = 1'b0;
        repeat (3) clk1();
        reset = 1'b1;
        exp_q.delete();
        repeat (3) clk1();
    endtask

    task automatic test_reset();
        int t1;
        int t2;
        bit width_ok;
        reset = 1'b0;
        repeat (3) clk1();
        n_cmp++;
        if (window !== 16'h0123) begin n_err++; $display("FAIL reset_window: window=%h, required 0123", window); end
        n_cmp++;
        if (base_idx !== 4'd0) begin n_err++; $display("FAIL reset_base: base_idx=%0d, required 0", base_idx); end
        n_cmp++;
        if (step_pulse !== 1'b0 || digit_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses: step_pulse=%b digit_tick=%b, required 0 0", step_pulse, digit_tick);
        end
        reset = 1'b1;
        t1 = -1;
        t2 = -1;
        width_ok = 1'b1;
        for (int i = 0; i < 30 && t1 < 0; i++) begin clk1(); if (digit_tick) t1 = cyc; end
        clk1();
        if (digit_tick) width_ok = 1'b0;
        for (int i = 0; i < 30 && t2 < 0; i++) begin clk1(); if (digit_tick) t2 = cyc; end
        n_cmp++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) != TD) begin
            n_err++;
            $display("FAIL tick_period: period=%0d (t1=%0d t2=%0d), required %0d", t2 - t1, t1, t2, TD);
        end
        n_cmp++;
        if (!width_ok) begin n_err++; $display("FAIL tick_width: digit_tick high 2+ cycles, required 1"); end
    endtask

    task automatic test_debounce();
        int s1;
        int s2;
        int t;
        int t0;
        int k;
        do_reset();
        btn_n = 1'b0;
        idle(3, s1);
        btn_n = 1'b1;
        idle(12, s2);
        n_cmp++;
        if (s1 + s2 != 0 || base_idx !== 4'd0) begin
            n_err++;
            $display("FAIL short_press: steps=%0d base_idx=%0d, required 0 0", s1 + s2, base_idx);
        end
        exp_q.push_back(4);
        btn_n = 1'b0;
        t0 = cyc;
        wait_step("debounce_press", 10, t);
        k = (t < 0) ? 10 : t - t0;
        idle((k < 10) ? 10 - k : 0, s1);
        btn_n = 1'b1;
        idle(12, s2);
        n_cmp++;
        if (s1 + s2 != 0) begin n_err++; $display("FAIL debounce_extra: extra steps=%0d, required 0", s1 + s2); end
        n_cmp++;
        if (base_idx !== 4'd4 || window !== 16'h4567) begin
            n_err++;
            $display("FAIL debounce_result: base_idx=%0d window=%h, required 4 4567", base_idx, window);
        end
    endtask

    task automatic test_wrap();
        int s1;
        int s2;
        int t;
        int t0;
        int hold;
        int k;
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            hold = (p == 1) ? 30 : 10;
            exp_q.push_back((4 * p) % 16);
            btn_n = 1'b0;
            t0 = cyc;
            wait_step("wrap_press", 20, t);
            k = (t < 0) ? hold : t - t0;
            idle((k < hold) ? hold - k : 0, s1);
            btn_n = 1'b1;
            idle(12, s2);
            n_cmp++;
            if (s1 + s2 != 0 || base_idx !== 4'((4 * p) % 16)) begin
                n_err++;
                $display("FAIL wrap_step%0d: extra=%0d base_idx=%0d, required 0 %0d", p, s1 + s2, base_idx, (4 * p) % 16);
            end
            if (p == 3) begin
                n_cmp++;
                if (window !== 16'h2345) begin n_err++; $display("FAIL wrap_window12: window=%h, required 2345", window); end
            end
        end
    endtask

    task automatic test_auto();
        int t;
        int prev;
        int s1;
        int s2;
        do_reset();
        auto_en = 1'b1;
        prev = -1;
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(i % 16);
            wait_step("auto", 40, t);
            if (prev >= 0) begin
                n_cmp++;
                if (t - prev != AUTO_PERIOD) begin
                    n_err++;
                    $display("FAIL auto_interval%0d: %0d cycles, required %0d", i, t - prev, AUTO_PERIOD);
                end
            end
            prev = t;
        end
        idle(12, s1);
        auto_en = 1'b0;
        idle(60, s2);
        n_cmp++;
        if (s1 + s2 != 0 || base_idx !== 4'd0) begin
            n_err++;
            $display("FAIL auto_freeze: steps=%0d base_idx=%0d, required 0 0", s1 + s2, base_idx);
        end
    endtask

    task automatic test_collision();
        int t;
        int t0;
        int lat;
        int ta;
        int s1;
        int s2;
        do_reset();
        exp_q.push_back(4);
        btn_n = 1'b0;
        t0 = cyc;
        wait_step("coll_cal", 20, t);
        lat = t - t0;
        idle(6, s1);
        btn_n = 1'b1;
        idle(12, s2);
        auto_en = 1'b1;
        exp_q.push_back(5);
        wait_step("coll_auto", 40, ta);
        n_cmp++;
        if (t < 0 || ta < 0 || lat < 1 || lat >= AUTO_PERIOD) begin
            n_err++;
            $display("FAIL coll_latency: page latency=%0d auto=%0d, required 1..%0d", lat, ta, AUTO_PERIOD - 1);
        end else begin
            while (cyc < ta + AUTO_PERIOD - lat) clk1();
            btn_n = 1'b0;
            exp_q.push_back(9);
            wait_step("coll_step", 30, t);
            n_cmp++;
            if (t != ta + AUTO_PERIOD) begin
                n_err++;
                $display("FAIL coll_align: step at %0d, required %0d", t, ta + AUTO_PERIOD);
            end
            idle(6, s1);
            btn_n = 1'b1;
            exp_q.push_back(10);
            wait_step("coll_next", 40, t);
            n_cmp++;
            if (s1 != 0 || t != ta + 2 * AUTO_PERIOD) begin
                n_err++;
                $display("FAIL coll_next: extra=%0d next at %0d, required 0 %0d", s1, t, ta + 2 * AUTO_PERIOD);
            end
        end
        auto_en = 1'b0;
        btn_n = 1'b1;
        idle(12, s2);
    endtask

    task automatic test_write();
        int s1;
        int s2;
        int t;
        do_reset();
        wr_en = 1'b1;
        wr_addr = 4'd2;
        wr_data = 4'hA;
        clk1();
        wr_en = 1'b0;
        n_cmp++;
        if (window !== 16'h0123) begin n_err++; $display("FAIL write_early: window=%h, required 0123", window); end
        clk1();
        n_cmp++;
        if (window !== 16'h01A3) begin n_err++; $display("FAIL write_window: window=%h, required 01a3", window); end
        wr_en = 1'b1;
        wr_addr = 4'd9;
        wr_data = 4'hF;
        clk1();
        wr_en = 1'b0;
        clk1();
        n_cmp++;
        if (window !== 16'h01A3) begin n_err++; $display("FAIL write_outside: window=%h, required 01a3", window); end
        exp_q.push_back(4);
        btn_n = 1'b0;
        wait_step("write_press", 20, t);
        btn_n = 1'b1;
        idle(12, s1);
        n_cmp++;
        if (window !== 16'h4567 || base_idx !== 4'd4) begin
            n_err++;
            $display("FAIL write_page: window=%h base_idx=%0d, required 4567 4", window, base_idx);
        end
        btn_n = 1'b0;
        idle(4, s1);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (base_idx !== 4'd0 || window !== 16'h0123) begin
            n_err++;
            $display("FAIL async_reset: base_idx=%0d window=%h, required 0 0123", base_idx, window);
        end
        btn_n = 1'b1;
        idle(2, s2);
        reset = 1'b1;
        idle(40, s2);
        n_cmp++;
        if (s1 + s2 != 0 || base_idx !== 4'd0 || window !== 16'h0123) begin
            n_err++;
            $display("FAIL reset_mid_db: steps=%0d base_idx=%0d window=%h, required 0 0 0123", s1 + s2, base_idx, window);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_auto();
        test_collision();
        test_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
